// File: rtl/delta_sigma_dac_pkg.sv
// Shared constants for the first-order pulse-density DAC.
// Holds only the default code width; the width itself stays a module parameter
// so different instances can use different resolutions.
package delta_sigma_dac_pkg;

  // Default input code width in bits. Legal range for WIDTH is 2..32.
  localparam int DSD_DEFAULT_WIDTH = 10;

endpackage : delta_sigma_dac_pkg

// File: rtl/delta_sigma_dac.sv
// First-order delta-sigma (pulse-density) DAC for driving a pin into an external RC filter.
// Latency: DAC_in sampled at edge n shows up in DAC_out right after edge n (registered output).
// Backpressure: none; DAC_in is consumed every cycle and may change on any cycle.
//
// Ports:
//   clk      in   1      rising-edge clock
//   rst      in   1      synchronous active-high reset (clears accumulator and output)
//   DAC_in   in   WIDTH  unsigned target code; density of ones = DAC_in / 2^WIDTH
//   DAC_out  out  1      registered pulse-density bit stream
module delta_sigma_dac
  import delta_sigma_dac_pkg::*;
#(
  parameter int WIDTH = DSD_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] DAC_in,
  output logic             DAC_out
);

  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_d;
  logic             dac_out_q;
  logic             dac_out_d;
  logic [WIDTH:0]   sum;

  // The carry of acc + code is the output bit; the wrapped remainder is the
  // residual error kept for the next cycle. A code change never clears acc,
  // so the error left by the old code carries into the new one.
  always_comb begin
    sum       = {1'b0, acc_q} + {1'b0, DAC_in};
    acc_d     = sum[WIDTH-1:0];
    dac_out_d = sum[WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q     <= '0;
      dac_out_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      dac_out_q <= dac_out_d;
    end
  end

  assign DAC_out = dac_out_q;

endmodule : delta_sigma_dac

// File: tb/tb_delta_sigma_dac.sv
// Directed testbench for delta_sigma_dac with WIDTH=10.
module tb_delta_sigma_dac;

  localparam int W = 10;

  logic         clk;
  logic         rst;
  logic [W-1:0] DAC_in;
  logic         DAC_out;

  int n_tests;
  int n_fail;

  delta_sigma_dac #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .DAC_in  (DAC_in),
    .DAC_out (DAC_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 ns past it; outputs are sampled here
  // and inputs are changed here, well away from the next edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    DAC_in = 10'h2AB;
    pulse_reset();
    n_tests++;
    if (DAC_out !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_out: got %b expected 0", DAC_out);
    end
    n_tests++;
    if (dut.acc_q !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_acc: got %0d expected 0", dut.acc_q);
    end
  endtask

  task automatic test_zero_code();
    int ones;
    DAC_in = 10'd0;
    pulse_reset();
    ones = 0;
    for (int i = 0; i < 2048; i++) begin
      step();
      if (DAC_out !== 1'b0) ones++;
    end
    n_tests++;
    if (ones !== 0) begin
      n_fail++;
      $display("FAIL zero_code: %0d non-zero cycles, expected 0", ones);
    end
  endtask

  task automatic test_half_scale();
    logic exp_bit;
    int   bad;
    DAC_in = 10'h200;
    pulse_reset();
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      exp_bit = (i % 2 == 1);
      if (DAC_out !== exp_bit) begin
        bad++;
        $display("FAIL half_scale[%0d]: got %b expected %b", i, DAC_out, exp_bit);
      end
    end
    n_tests++;
    if (bad != 0) n_fail++;
  endtask

  task automatic test_full_scale();
    int ones;
    int zeros;
    int zero_pos;
    DAC_in = 10'h3FF;
    pulse_reset();
    ones = 0; zeros = 0; zero_pos = -1;
    for (int i = 0; i < 1024; i++) begin
      step();
      if (DAC_out === 1'b1) ones++;
      else if (DAC_out === 1'b0) begin
        zeros++;
        zero_pos = i;
      end
    end
    n_tests++;
    if (ones !== 1023) begin
      n_fail++;
      $display("FAIL full_scale_ones: got %0d expected 1023", ones);
    end
    n_tests++;
    if (zeros !== 1 || zero_pos !== 0) begin
      n_fail++;
      $display("FAIL full_scale_zero: got %0d zeros at %0d expected 1 at 0", zeros, zero_pos);
    end
  endtask

  task automatic test_ramp_down();
    int exp_ones [9] = '{1023, 895, 767, 639, 511, 383, 255, 127, 0};
    int ones;
    int code;
    for (int k = 0; k < 9; k++) begin
      code   = (1023 * (8 - k)) / 8;
      DAC_in = code[W-1:0];
      pulse_reset();
      ones = 0;
      for (int i = 0; i < 1024; i++) begin
        step();
        if (DAC_out === 1'b1) ones++;
      end
      n_tests++;
      if (ones !== exp_ones[k]) begin
        n_fail++;
        $display("FAIL ramp_window[%0d]: got %0d ones expected %0d", k, ones, exp_ones[k]);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic fresh [64];
    logic first4 [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    int   bad;
    DAC_in = 10'h155;
    pulse_reset();
    for (int i = 0; i < 64; i++) begin
      step();
      fresh[i] = DAC_out;
    end
    // 0x155 = 341: sums 341, 682, 1023, 1364 -> first carry on the 4th edge.
    bad = 0;
    for (int i = 0; i < 4; i++)
      if (fresh[i] !== first4[i]) bad++;
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL mid_reset_fresh_start: %0d of first 4 bits wrong (got %b%b%b%b expected 0001)",
               bad, fresh[0], fresh[1], fresh[2], fresh[3]);
    end

    pulse_reset();
    for (int i = 0; i < 37; i++) step();
    pulse_reset();
    n_tests++;
    if (DAC_out !== 1'b0 || dut.acc_q !== 10'd0) begin
      n_fail++;
      $display("FAIL mid_reset_state: out=%b acc=%0d expected out=0 acc=0", DAC_out, dut.acc_q);
    end
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      step();
      if (DAC_out !== fresh[i]) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL mid_reset_replay: %0d bits differ from fresh run, expected 0", bad);
    end
  endtask

  task automatic test_code_step();
    int   acc_m;
    int   code;
    logic exp_bit;
    int   bad;
    int   ones;
    logic first5 [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    DAC_in = 10'h100;
    pulse_reset();
    acc_m = 0;
    bad   = 0;
    for (int i = 0; i < 40; i++) begin
      code    = (i < 5) ? 'h100 : 'h300;
      DAC_in  = code[W-1:0];
      exp_bit = ((acc_m + code) >= 1024);
      acc_m   = (acc_m + code) % 1024;
      step();
      if (DAC_out !== exp_bit) begin
        bad++;
        $display("FAIL code_step[%0d]: got %b expected %b", i, DAC_out, exp_bit);
      end
      if (i < 5 && DAC_out !== first5[i]) begin
        bad++;
        $display("FAIL code_step_hand[%0d]: got %b expected %b", i, DAC_out, first5[i]);
      end
    end
    n_tests++;
    if (bad != 0) n_fail++;

    ones = 0;
    for (int i = 0; i < 1024; i++) begin
      step();
      if (DAC_out === 1'b1) ones++;
    end
    n_tests++;
    if (ones !== 'h300) begin
      n_fail++;
      $display("FAIL code_step_density: got %0d ones expected 768", ones);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    DAC_in  = '0;
    test_reset();
    test_zero_code();
    test_half_scale();
    test_full_scale();
    test_ramp_down();
    test_mid_reset();
    test_code_step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_delta_sigma_dac
